iob_fifo_t2p_ctrl: RTL
======================

// Module: iob_fifo_t2p_ctrl
// PURPOSE
//  Synchronous FIFO controller that drives an external iob_ram_t2p instance through its
//  write/read ports. It owns the pointers, the level count and the full/empty flags,
//  and returns RAM read data to the consumer with a valid strobe. The RAM sits outside
//  the block so the same controller serves any RAM macro or inferred memory.
// PARAMETERS
//  DATA_W  8  FIFO word width; equals the RAM DATA_W.
//  ADDR_W  4  RAM address width; depth = 2**ADDR_W words (ADDR_W >= 1).
// PORTS
//  clk_i             in   1         clock; all logic rises on posedge
//  arst_n_i          in   1         asynchronous, active-low reset
//  w_en_i            in   1         push request
//  w_data_i          in   DATA_W    push data
//  w_full_o          out  1         FIFO full; a push is dropped while high
//  r_en_i            in   1         pop request
//  r_data_o          out  DATA_W    popped data, qualified by r_valid_o
//  r_valid_o         out  1         r_data_o holds the word popped in the previous cycle
//  r_empty_o         out  1         FIFO empty; a pop is dropped while high
//  level_o           out  ADDR_W+1  words stored, 0..2**ADDR_W
//  ovf_o             out  1         sticky: a push was dropped while full
//  udf_o             out  1         sticky: a pop was dropped while empty
//  ext_mem_w_en_o    out  1         to RAM w_en_i
//  ext_mem_w_addr_o  out  ADDR_W    to RAM w_addr_i
//  ext_mem_w_data_o  out  DATA_W    to RAM w_data_i
//  ext_mem_r_en_o    out  1         to RAM r_en_i
//  ext_mem_r_addr_o  out  ADDR_W    to RAM r_addr_i
//  ext_mem_r_data_i  in   DATA_W    from RAM r_data_o; 1-cycle registered read
// BEHAVIOUR
//  - Reset (async assert, sync release) values:
//    w_ptr = 0, r_ptr = 0, level_o = 0, r_empty_o = 1, w_full_o = 0, r_valid_o = 0,
//    ovf_o = 0, udf_o = 0.
//  - Reset mid-operation discards all contents. RAM data is not cleared; it is stale
//    and must never be returned.
//  - push_ok = w_en_i & ~w_full_o; pop_ok = r_en_i & ~r_empty_o.
//    Both use the flag values registered at the start of the cycle.
//  - ext_mem_w_en_o = push_ok; ext_mem_w_addr_o = w_ptr; ext_mem_w_data_o = w_data_i.
//    All three are combinational.
//  - ext_mem_r_en_o = pop_ok; ext_mem_r_addr_o = r_ptr. Both are combinational.
//  - Pointers are ADDR_W bits and wrap from 2**ADDR_W-1 to 0.
//    w_ptr increments on push_ok; r_ptr increments on pop_ok.
//  - level_o next value:
//    - +1 on push only;
//    - -1 on pop only;
//    - unchanged on both or neither.
//  - Flags are registered from the next level value:
//    - r_empty_o = (level == 0);
//    - w_full_o = (level == 2**ADDR_W).
//  - Read latency is 1 cycle. r_valid_o <= pop_ok. r_data_o = ext_mem_r_data_i
//    (pass-through). r_data_o is don't-care while r_valid_o is low.
//  - When empty, a pop in the same cycle as a push is dropped (udf_o sets). The pushed
//    word is readable from the next cycle onward, so there is no write-to-read bypass.
//  - When full, a push in the same cycle as a pop is dropped (ovf_o sets); the pop
//    proceeds. This guarantees read and write addresses never collide on a live word.
//  - When neither full nor empty, a simultaneous push and pop are both accepted and
//    level_o holds.
//  - ovf_o and udf_o are cleared only by reset.
//  - No combinational path from r_en_i or w_en_i to any flag.
// TESTING
//  1. Reset, ADDR_W=4: push 0x01..0x10 -> full=1 and level=16 after the 16th push.
//     A 17th push -> ovf=1, level stays 16, ext_mem_w_en_o=0.
//  2. From full, pop 16x -> r_valid=1 one cycle after each pop, data 0x01..0x10 in
//     order, empty=1 at end. An extra pop -> udf=1, no r_valid.
//  3. Level 5, push+pop every cycle for 40 cycles -> level stays 5, both pointers
//     wrap, output order is preserved.
//  4. Empty, push 0xAA and pop in the same cycle -> pop dropped, udf=1, level=1.
//     Pop next cycle -> 0xAA with r_valid.
//  5. Full, push 0x55 and pop in the same cycle -> push dropped, ovf=1, level=15,
//     oldest word returned.
//  6. Level 7, assert arst_n_i low mid-burst -> all outputs at reset values
//     immediately. After release, the first pop attempt is refused (empty=1).

Source files
------------

// File: rtl/iob_fifo_t2p_ctrl.sv
// Synchronous FIFO controller for an external two-port RAM with a 1-cycle registered read.
// Owns the pointers, level and flags; read data passes straight through from the RAM.
module iob_fifo_t2p_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              w_en_i,
   input  logic [DATA_W-1:0] w_data_i,
   output logic              w_full_o,
   input  logic              r_en_i,
   output logic [DATA_W-1:0] r_data_o,
   output logic              r_valid_o,
   output logic              r_empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              ovf_o,
   output logic              udf_o,
   output logic              ext_mem_w_en_o,
   output logic [ADDR_W-1:0] ext_mem_w_addr_o,
   output logic [DATA_W-1:0] ext_mem_w_data_o,
   output logic              ext_mem_r_en_o,
   output logic [ADDR_W-1:0] ext_mem_r_addr_o,
   input  logic [DATA_W-1:0] ext_mem_r_data_i
);

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   LVL_ONE = 1;
   localparam logic [ADDR_W:0]   LVL_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] w_ptr;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   level_nxt;
   logic              push_ok;
   logic              pop_ok;

   // Flags are registered, so acceptance never depends combinationally on themselves
   assign push_ok = w_en_i & ~w_full_o;
   assign pop_ok  = r_en_i & ~r_empty_o;

   assign ext_mem_w_en_o   = push_ok;
   assign ext_mem_w_addr_o = w_ptr;
   assign ext_mem_w_data_o = w_data_i;
   assign ext_mem_r_en_o   = pop_ok;
   assign ext_mem_r_addr_o = r_ptr;
   assign r_data_o         = ext_mem_r_data_i;

   always_comb begin
      level_nxt = level_o;
      if (push_ok && !pop_ok) begin
         level_nxt = level_o + LVL_ONE;
      end else if (pop_ok && !push_ok) begin
         level_nxt = level_o - LVL_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         level_o   <= '0;
         r_empty_o <= 1'b1;
         w_full_o  <= 1'b0;
         r_valid_o <= 1'b0;
         ovf_o     <= 1'b0;
         udf_o     <= 1'b0;
      end else begin
         if (push_ok) begin
            w_ptr <= w_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            r_ptr <= r_ptr + PTR_ONE;
         end
         level_o   <= level_nxt;
         r_empty_o <= (level_nxt == '0);
         w_full_o  <= (level_nxt == LVL_MAX);
         r_valid_o <= pop_ok;
         if (w_en_i && w_full_o) begin
            ovf_o <= 1'b1;
         end
         if (r_en_i && r_empty_o) begin
            udf_o <= 1'b1;
         end
      end
   end

endmodule
